// File: rtl/prefix_accumulator_pkg.sv
// Shared definitions for the prefix accumulator and its adder:
// default widths and the controller state encoding.
package prefix_accumulator_pkg;

    localparam int ACC_N     = 64;
    localparam int ACC_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/N_bit_Ladner_fischer_adder.sv
// N-bit Ladner-Fischer parallel prefix adder, fully combinational.
// Carry-in is folded into the bit-0 generate term so the prefix tree yields every carry.
module N_bit_Ladner_fischer_adder
    import prefix_accumulator_pkg::*;
#(
    parameter int N = ACC_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    localparam int LV = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] p0;
    logic [N-1:0] gCur;
    logic [N-1:0] pCur;
    logic [N-1:0] gNxt;
    logic [N-1:0] pNxt;

    // Each level merges a bit with the last bit of the preceding 2^l-wide block.
    always_comb begin
        p0      = a ^ b;
        gCur    = a & b;
        gCur[0] = gCur[0] | (p0[0] & cin);
        pCur    = p0;
        gNxt    = gCur;
        pNxt    = pCur;
        for (int l = 0; l < LV; l++) begin
            gNxt = gCur;
            pNxt = pCur;
            for (int i = 0; i < N; i++) begin
                if (((i >> l) & 1) == 1) begin
                    gNxt[i] = gCur[i] | (pCur[i] & gCur[((i >> l) << l) - 1]);
                    pNxt[i] = pCur[i] & pCur[((i >> l) << l) - 1];
                end
            end
            gCur = gNxt;
            pCur = pNxt;
        end
    end

    assign s    = p0 ^ {gCur[N-2:0], cin};
    assign cout = gCur[N-1];

endmodule

// File: rtl/prefix_accumulator.sv
// Streams a job of len operands through the prefix adder into a running sum,
// counting carry-outs so {out_hi, out_sum} is the exact unsigned total.
module prefix_accumulator
    import prefix_accumulator_pkg::*;
#(
    parameter int N     = ACC_N,
    parameter int CNT_W = ACC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic [CNT_W-1:0] out_hi,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [N-1:0]     addSum;
    logic             addCout;
    logic             beat;

    N_bit_Ladner_fischer_adder #(
        .N(N)
    ) u_adder (
        .a   (acc_q),
        .b   (in_data),
        .cin (1'b0),
        .s   (addSum),
        .cout(addCout)
    );

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ACCUM) || (state_q == DONE);
    assign beat      = in_valid & in_ready;
    assign out_sum   = acc_q;
    assign out_hi    = hi_q;

    // A start seen together with the DONE handshake is dropped; it must come again in IDLE.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        hi_d        = hi_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d       = '0;
                    hi_d        = '0;
                    remaining_d = len;
                    state_d     = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d       = addSum;
                    hi_d        = hi_q + CNT_W'(addCout);
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            hi_q        <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            hi_q        <= hi_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_prefix_accumulator.sv
// Self-checking bench for prefix_accumulator: directed vector table, corner sequences,
// and random jobs compared against a wide-integer sum of the operands.
module tb_prefix_accumulator;

    localparam int N     = 64;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic [CNT_W-1:0] out_hi;
    logic             busy;

    int compared;
    int mismatched;

    logic [N-1:0] opQ[$];

    typedef struct {
        int                len;
        logic [3:0][N-1:0] ops;
        logic [N-1:0]      expSum;
        logic [CNT_W-1:0]  expHi;
    } vec_t;

    vec_t vecs[3];

    prefix_accumulator #(
        .N(N),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_hi   (out_hi),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs one job from opQ; inputs change and outputs are sampled on the falling edge.
    task automatic applyStimulus(input string tag, input int lenIn, input int maxGap,
                                 input int readyDelay, input logic [N-1:0] expSum,
                                 input logic [CNT_W-1:0] expHi);
        @(negedge clk);
        start = 1'b1;
        len   = CNT_W'(lenIn);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < lenIn; k++) begin
            int gap;
            gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            in_data  = opQ[k];
            checkOutput({tag, " in_ready"}, N'(in_ready), N'(1));
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = $urandom;
        end
        checkOutput({tag, " out_valid"}, N'(out_valid), N'(1));
        checkOutput({tag, " busy"}, N'(busy), N'(1));
        checkOutput({tag, " out_sum"}, out_sum, expSum);
        checkOutput({tag, " out_hi"}, N'(out_hi), N'(expHi));
        repeat (readyDelay) begin
            @(negedge clk);
            checkOutput({tag, " held out_valid"}, N'(out_valid), N'(1));
            checkOutput({tag, " held out_sum"}, out_sum, expSum);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, " out_valid after handshake"}, N'(out_valid), N'(0));
        checkOutput({tag, " busy after handshake"}, N'(busy), N'(0));
    endtask

    initial begin
        logic [N+CNT_W-1:0] total;
        logic [N-1:0]       op;
        logic [N-1:0]       heldSum;
        int                 jl;

        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        start      = 1'b0;
        len        = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;

        #1;
        checkOutput("reset out_valid", N'(out_valid), N'(0));
        checkOutput("reset in_ready", N'(in_ready), N'(0));
        checkOutput("reset busy", N'(busy), N'(0));
        checkOutput("reset out_sum", out_sum, N'(0));
        checkOutput("reset out_hi", N'(out_hi), N'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        vecs[0].len = 2;
        vecs[0].ops = {64'd0, 64'd0, 64'd10, 64'd15};
        vecs[0].expSum = 64'd25;
        vecs[0].expHi  = 8'd0;
        vecs[1].len = 3;
        vecs[1].ops = {64'd0, 64'd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1].expSum = 64'd1;
        vecs[1].expHi  = 8'd1;
        vecs[2].len = 2;
        vecs[2].ops = {64'd0, 64'd0, 64'hFEDC_BA98_7654_3210, 64'h1234_5678_9ABC_DEF0};
        vecs[2].expSum = 64'h1111_1111_1111_1100;
        vecs[2].expHi  = 8'd1;

        for (int v = 0; v < 3; v++) begin
            opQ.delete();
            for (int k = 0; k < vecs[v].len; k++) opQ.push_back(vecs[v].ops[k]);
            applyStimulus($sformatf("vec%0d", v), vecs[v].len, 0, 0, vecs[v].expSum, vecs[v].expHi);
        end

        // len==0: result the cycle after start, then held while stray start/in_valid arrive.
        @(negedge clk);
        start = 1'b1;
        len   = 8'd0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("len0 out_valid", N'(out_valid), N'(1));
        checkOutput("len0 out_sum", out_sum, N'(0));
        checkOutput("len0 out_hi", N'(out_hi), N'(0));
        for (int c = 0; c < 5; c++) begin
            start    = c[0];
            len      = 8'd3;
            in_valid = 1'b1;
            in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
            @(negedge clk);
            checkOutput("len0 hold out_valid", N'(out_valid), N'(1));
            checkOutput("len0 hold out_sum", out_sum, N'(0));
            checkOutput("len0 hold out_hi", N'(out_hi), N'(0));
        end
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        checkOutput("start with handshake busy", N'(busy), N'(0));
        checkOutput("start with handshake in_ready", N'(in_ready), N'(0));
        checkOutput("start with handshake out_valid", N'(out_valid), N'(0));
        @(negedge clk);
        checkOutput("idle in_valid ignored", out_sum, N'(0));
        in_valid = 1'b0;

        // Asynchronous reset in the middle of a job.
        @(negedge clk);
        start = 1'b1;
        len   = 8'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'd100;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'd200;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("midjob partial sum", out_sum, N'(300));
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst out_sum", out_sum, N'(0));
        checkOutput("async rst busy", N'(busy), N'(0));
        checkOutput("async rst in_ready", N'(in_ready), N'(0));
        checkOutput("async rst out_valid", N'(out_valid), N'(0));
        @(negedge clk);
        rst = 1'b0;
        opQ.delete();
        opQ.push_back(64'd7);
        applyStimulus("after reset", 1, 0, 0, 64'd7, 8'd0);

        // Random jobs against an exact wide-integer total.
        for (int j = 0; j < 25; j++) begin
            jl    = int'($urandom_range(0, 12));
            total = '0;
            opQ.delete();
            for (int k = 0; k < jl; k++) begin
                if ($urandom_range(0, 3) == 0) op = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 15));
                else op = {$urandom, $urandom};
                opQ.push_back(op);
                total = total + (N+CNT_W)'(op);
            end
            applyStimulus($sformatf("rand%0d", j), jl, 2, int'($urandom_range(0, 3)),
                          total[N-1:0], total[N+CNT_W-1:N]);
            heldSum = total[N-1:0];
            checkOutput($sformatf("rand%0d idle keeps sum", j), out_sum, heldSum);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
